// File: rtl/rr_arb_mux4_if.sv
// rr_arb_mux4_if: valid/ready bundle around the 4-way round-robin arbiter.
// Ports: in_valid/in_data/in_ready (requester side), out_valid/out_data/out_src/out_ready (downstream side).
interface rr_arb_mux4_if #(
    parameter int WIDTH = 2
);
    logic [3:0]            in_valid;
    logic [3:0][WIDTH-1:0] in_data;
    logic [3:0]            in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [1:0]            out_src;
    logic                  out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_src
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_src
    );
endinterface

// File: rtl/rr_arb_mux4.sv
// rr_arb_mux4: fair 4-input round-robin arbiter feeding a one-hot AND-OR mux and output register.
// Ports: clk, rst_n (async active-low), bus (slave modport: requesters in, registered beat out).
module rr_arb_mux4 #(
    parameter int WIDTH = 2
) (
    input logic         clk,
    input logic         rst_n,
    rr_arb_mux4_if.slave bus
);
    logic [1:0]       ptr;
    logic             can_load;
    logic [3:0]       gnt;
    logic [1:0]       gnt_idx;
    logic [3:0]       ready;
    logic [WIDTH-1:0] sel_data;
    logic             fire;

    logic             ov_q;
    logic [WIDTH-1:0] od_q;
    logic [1:0]       os_q;

    assign can_load = !ov_q || bus.out_ready;

    // Scan starts at ptr and wraps; first valid requester wins.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found   = 1'b0;
        idx     = 2'd0;
        gnt     = 4'b0000;
        gnt_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && bus.in_valid[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

    // Ready is suppressed during reset so no beat is offered while the
    // output register is being cleared.
    assign ready        = (can_load && rst_n) ? gnt : 4'b0000;
    assign fire         = |ready;
    assign bus.in_ready = ready;

    // One-hot AND-OR select: no priority chain on the data path.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < 4; i++) begin
            sel_data = sel_data | (bus.in_data[i] & {WIDTH{gnt[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr  <= 2'd0;
            ov_q <= 1'b0;
            od_q <= '0;
            os_q <= 2'd0;
        end else if (fire) begin
            ov_q <= 1'b1;
            od_q <= sel_data;
            os_q <= gnt_idx;
            ptr  <= gnt_idx + 2'd1;
        end else if (bus.out_ready) begin
            ov_q <= 1'b0;
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_src   = os_q;
endmodule

// File: tb/tb_rr_arb_mux4.sv
// tb_rr_arb_mux4: scoreboard bench for rr_arb_mux4.
// Drives requesters/out_ready, models arbitration, compares beats at negedge.
module tb_rr_arb_mux4;
    localparam int W = 2;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   src;
    } beat_t;

    logic clk;
    logic rst_n;
    rr_arb_mux4_if #(.WIDTH(W)) bus ();

    rr_arb_mux4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    beat_t            sb[$];
    logic [1:0]       m_ptr;
    logic             m_ov;
    logic [3:0][W-1:0] dat;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 2'd0;
        m_ov  = 1'b0;
        sb.delete();
    endtask

    // One clock cycle: drive, check/update model at negedge, pass the edge.
    task automatic cyc(input logic [3:0] v, input logic r);
        logic [3:0] mg;
        logic [3:0] exp_rdy;
        logic [1:0] mi;
        logic [1:0] idx;
        logic       found;
        beat_t      b;
        bus.in_valid  = v;
        bus.out_ready = r;
        bus.in_data   = dat;
        @(negedge clk);
        mg    = 4'b0000;
        mi    = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = m_ptr + 2'(k);
            if (!found && v[idx]) begin
                found   = 1'b1;
                mg[idx] = 1'b1;
                mi      = idx;
            end
        end
        exp_rdy = (!m_ov || r) ? mg : 4'b0000;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        if (m_ov) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                chk("out_data", 32'(bus.out_data), 32'(sb[0].data));
                chk("out_src", 32'(bus.out_src), 32'(sb[0].src));
                if (r) void'(sb.pop_front());
            end
        end
        if (exp_rdy != 4'b0000) begin
            b.data = dat[mi];
            b.src  = mi;
            sb.push_back(b);
            m_ptr = mi + 2'd1;
            m_ov  = 1'b1;
        end else if (r) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ident();
        for (int i = 0; i < 4; i++) dat[i] = W'(i);
    endtask

    initial begin
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        set_ident();
        bus.in_valid  = 4'b1111;
        bus.in_data   = dat;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_src", 32'(bus.out_src), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round robin with every requester pending.
        for (int k = 0; k < 6; k++) begin
            cyc(4'b1111, 1'b1);
            chk("rr_src", 32'(bus.out_src), 32'(seq[k]));
            chk("rr_data", 32'(bus.out_data), 32'(seq[k]));
        end

        // Sparse requests and wrap: ptr 2 -> grant 2 -> ptr 3.
        for (int i = 0; i < 4; i++) dat[i] = W'(3 - i);
        cyc(4'b0100, 1'b1);
        cyc(4'b0010, 1'b1);
        chk("sparse_src1", 32'(bus.out_src), 32'd1);
        cyc(4'b0001, 1'b1);
        chk("wrap_src0", 32'(bus.out_src), 32'd0);
        chk("wrap_data", 32'(bus.out_data), 32'd3);

        // Drain with nothing pending, ptr must stay at 1.
        set_ident();
        cyc(4'b0000, 1'b1);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        cyc(4'b1111, 1'b1);
        chk("ptr_hold_src", 32'(bus.out_src), 32'd1);

        // Backpressure holding a beat from requester 2.
        cyc(4'b0100, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0100, 1'b0);
            chk("stall_data", 32'(bus.out_data), 32'd2);
        end
        cyc(4'b0100, 1'b1);
        chk("unstall_src", 32'(bus.out_src), 32'd2);
        chk("unstall_valid", 32'(bus.out_valid), 32'd1);

        // Asynchronous reset mid-cycle: out_valid=1, out_src=2, ptr=3.
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_data", 32'(bus.out_data), 32'd0);
        chk("arst_src", 32'(bus.out_src), 32'd0);
        chk("arst_ready", 32'(bus.in_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'b1111, 1'b1);
        chk("restart_src", 32'(bus.out_src), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < 4; i++) dat[i] = W'($urandom_range(0, 3));
            cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b1);
        chk("final_idle", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rr_arb_mux4.md
# rr_arb_mux4

Four-input round-robin arbiter with a registered output stage. It selects one of four valid/ready requesters, forwards its WIDTH-bit data and source index, and sits directly upstream of the AND-OR 4:1 mux datapath. It therefore supplies both the select vector and the held operand that the mux consumes. Selection is fair: after a grant, the granted input drops to lowest priority.

## Interface

Parameters:
- WIDTH, 2, data width of each input and of the output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk (external synchroniser).
- in_valid  input  4  per-requester valid; bit i belongs to requester i.
- in_data  input  4 x WIDTH  packed; in_data[i] is requester i's data.
- in_ready  output  4  one-hot or zero; bit i high means requester i's beat is accepted this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  data of the held beat.
- out_src  output  2  index of the requester that produced the held beat.
- out_ready  input  1  downstream accepts the held beat this cycle.

## Operation

- State:
  - ptr[1:0], the highest-priority requester.
  - Output register {out_valid, out_data, out_src}.
- can_load = !out_valid || out_ready.
- Grant (combinational): the first requester with in_valid set, scanning ptr, ptr+1, ptr+2, ptr+3 mod 4.
  - The grant is a one-hot vector gnt[3:0].
  - gnt = 0 when no in_valid bit is set.
- in_ready = gnt when can_load is true, otherwise 4'b0000.
  - At most one in_ready bit is ever high.
- Data select is an AND-OR one-hot mux: each in_data[i] is masked by replicated gnt[i], then the four terms are OR-ed. There is no priority chain in the datapath.
- On a clock edge with any in_ready bit set (grant to requester i):
  - out_data <= selected data
  - out_src <= i
  - out_valid <= 1
  - ptr <= (i+1) mod 4, wrapping 3 -> 0.
- On an edge with out_valid && out_ready and no grant: out_valid <= 0. out_data and out_src hold their last values.
- When there is no grant, ptr holds.
- When out_valid && !out_ready (stall): the output register and ptr hold, and in_ready = 0. Pending requesters keep their valid and data stable (standard valid/ready rule).
- Simultaneous drain and load: a new beat replaces the drained one in the same edge, giving sustained 1 beat per cycle.
- Reset (rst_n low, any time, including mid-transfer):
  - out_valid = 0, out_data = 0, out_src = 0, ptr = 0.
  - in_ready is forced to 0 while rst_n is low.
  - A held beat is discarded.

## Timing

- Latency: a beat accepted at edge N (in_valid[i] && in_ready[i] high in the cycle before edge N) appears on out_valid/out_data/out_src after edge N. That is 1 cycle.
- Throughput: 1 beat per cycle while out_ready stays high and any request is pending.
- in_ready has combinational paths from in_valid, ptr, out_valid and out_ready.
  - Upstream in_valid must not depend on in_ready.
  - There is no combinational path from in_valid or in_data to any out_* signal.
- Outputs out_* are driven only from flops.

## Test plan

- **Reset:** hold rst_n=0 with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_src=0. After release, the first grant goes to requester 0 (ptr=0).
- **Round-robin fairness:** in_valid=4'b1111 held, in_data={3,2,1,0} (requester i carries i), out_ready=1 -> out_src sequence 0,1,2,3,0,1 on consecutive cycles, out_data equal to out_src, out_valid continuously 1.
- **Sparse and wrap:**
  - ptr=3, only in_valid[1] set -> grant to 1, ptr becomes 2.
  - Next, in_valid={0,1} -> grant to 0 (scan 2,3,0), ptr becomes 1.
- **Backpressure:** out_valid=1 with out_data=2, out_ready=0 for 3 cycles, in_valid=4'b0100 -> in_ready=0 throughout, out_data holds 2. Raise out_ready -> requester 2 is granted that cycle and out_data=its data on the next cycle.
- **Drain with no requests:** out_valid=1, out_ready=1, in_valid=0 -> out_valid=0 after the edge, ptr unchanged.
- **Reset mid-operation:** assert rst_n asynchronously mid-cycle while out_valid=1, out_src=2, ptr=3 -> all outputs clear immediately, and after release arbitration restarts at requester 0.
